servo_slew_ctrl: RTL and testbench

- Motion sequencer in front of the JR servo PWM driver.
- Accepts queued position commands through a valid/ready handshake, each with a per-frame slew rate and a dwell time.
- Ramps the 8-bit position code DAT_o one step per servo frame toward each target, holds it for the dwell, then moves on to the next command.
- Frame timing comes from the driver's FRAME output, so every position update lands in a fixed place relative to the driver's sampling point.

---
 rtl/servo_slew_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_servo_slew_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: queued motion sequencer in front of the JR servo PWM driver.
//
// Position commands {POS, RATE, DWELL} are pushed into a small FIFO. Each one is
// popped in turn. DAT_o then ramps toward POS by at most RATE per servo frame and
// holds there for DWELL frames. DONE_o pulses when the hold ends. Frame timing
// comes from the rising edge of the driver's FRAME output.
//
// Ports:
//   CK_i        system clock (shared with the servo driver)
//   XARST_i     asynchronous active-low reset
//   CMD_VAL_i   command valid
//   CMD_RDY_o   command ready; a push happens when VAL and RDY are both high
//   CMD_POS_i   target position code
//   CMD_RATE_i  maximum step per frame (0 = jump to target)
//   CMD_DWELL_i frames to hold at the target before DONE
//   ABORT_i     level: flush queue, stop motion, hold position
//   FRAME_i     driver FRAME output, rises at each frame start
//   DAT_o       position code to the driver
//   BUSY_o      controller active or FIFO non-empty
//   DONE_o      one-cycle pulse at command completion
//   LEVEL_o     FIFO occupancy
module servo_slew_ctrl #(
  parameter int unsigned C_FIFO_DEPTH = 4,
  parameter logic [7:0]  C_INIT_POS   = 8'd128
) (
  input  logic                              CK_i,
  input  logic                              XARST_i,
  input  logic                              CMD_VAL_i,
  output logic                              CMD_RDY_o,
  input  logic [7:0]                        CMD_POS_i,
  input  logic [3:0]                        CMD_RATE_i,
  input  logic [7:0]                        CMD_DWELL_i,
  input  logic                              ABORT_i,
  input  logic                              FRAME_i,
  output logic [7:0]                        DAT_o,
  output logic                              BUSY_o,
  output logic                              DONE_o,
  output logic [$clog2(C_FIFO_DEPTH):0]     LEVEL_o
);

  localparam int unsigned AW = $clog2(C_FIFO_DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StLoad, StSlew, StDwell} state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO: entries are {POS[19:12], RATE[11:8], DWELL[7:0]}
  // ---------------------------------------------------------------------------
  logic [19:0] r_mem [C_FIFO_DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [19:0] w_head;

  state_e      r_state;
  state_e      w_state_nxt;

  assign w_empty   = (r_wptr == r_rptr);
  // Same slot index but different wrap bit means the FIFO is full.
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign CMD_RDY_o = ~w_full & ~ABORT_i;
  assign w_push    = CMD_VAL_i & CMD_RDY_o;
  assign w_pop     = (r_state == StLoad) & ~ABORT_i;
  assign w_head    = r_mem[r_rptr[AW-1:0]];
  assign LEVEL_o   = r_wptr - r_rptr;

  always_ff @(posedge CK_i) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {CMD_POS_i, CMD_RATE_i, CMD_DWELL_i};
    end
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (ABORT_i) begin
      r_rptr <= r_wptr;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrOne;
      if (w_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame tick. The edge register resets high so a FRAME already high at reset
  // release is not mistaken for a new frame.
  // ---------------------------------------------------------------------------
  logic r_frame;
  logic w_tick;
  logic r_tick_pend;
  logic w_tick_slew;

  assign w_tick = FRAME_i & ~r_frame;

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_frame     <= 1'b1;
      r_tick_pend <= 1'b0;
    end else begin
      r_frame     <= FRAME_i;
      // A tick landing in the LOAD cycle is carried into the first SLEW cycle.
      r_tick_pend <= (r_state == StLoad) & w_tick & ~ABORT_i;
    end
  end

  assign w_tick_slew = w_tick | r_tick_pend;

  // ---------------------------------------------------------------------------
  // Active command and slew arithmetic
  // ---------------------------------------------------------------------------
  logic [7:0]        r_tgt;
  logic [3:0]        r_rate;
  logic [7:0]        r_dwell;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic [7:0]        r_dat;
  logic [7:0]        w_dat_nxt;
  logic              w_done;
  logic signed [8:0] w_diff;
  logic [8:0]        w_mag;
  logic              w_arrive;
  logic [7:0]        w_step;

  assign w_diff   = $signed({1'b0, r_tgt}) - $signed({1'b0, r_dat});
  assign w_mag    = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
  assign w_arrive = (r_rate == 4'd0) || (w_mag <= {5'd0, r_rate});
  // Only used when not arriving, so the step never crosses the target or wraps.
  assign w_step   = w_diff[8] ? (r_dat - {4'd0, r_rate}) : (r_dat + {4'd0, r_rate});

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_tgt   <= '0;
      r_rate  <= '0;
      r_dwell <= '0;
    end else if (w_pop) begin
      r_tgt   <= w_head[19:12];
      r_rate  <= w_head[11:8];
      r_dwell <= w_head[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      r_state <= StIdle;
      r_dat   <= C_INIT_POS;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dat   <= w_dat_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dat_nxt   = r_dat;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) w_state_nxt = StLoad;
      end
      StLoad: begin
        w_state_nxt = StSlew;
      end
      StSlew: begin
        if (w_tick_slew) begin
          if (w_arrive) begin
            w_dat_nxt = r_tgt;
            if (r_dwell == 8'd0) begin
              w_done      = 1'b1;
              w_state_nxt = StIdle;
            end else begin
              w_cnt_nxt   = r_dwell;
              w_state_nxt = StDwell;
            end
          end else begin
            w_dat_nxt = w_step;
          end
        end
      end
      StDwell: begin
        if (w_tick) begin
          w_cnt_nxt = r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            w_done      = 1'b1;
            w_state_nxt = StIdle;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
    // Abort wins over everything: hold position, no completion.
    if (ABORT_i) begin
      w_state_nxt = StIdle;
      w_dat_nxt   = r_dat;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
    end
  end

  assign DAT_o  = r_dat;
  assign DONE_o = w_done;
  assign BUSY_o = (r_state != StIdle) | ~w_empty;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Scoreboard bench for servo_slew_ctrl. Each accepted command is expanded by a
// trajectory model into expected events (position changes and completions);
// a monitor pops and compares whenever DAT_o changes or DONE_o pulses.
module tb_servo_slew_ctrl;

  localparam int unsigned Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       val = 1'b0;
  logic       rdy;
  logic [7:0] cpos = '0;
  logic [3:0] crate = '0;
  logic [7:0] cdwell = '0;
  logic       abort = 1'b0;
  logic       frame = 1'b1;
  logic [7:0] dat;
  logic       busy;
  logic       done;
  logic [2:0] level;

  always #5 clk = ~clk;

  servo_slew_ctrl #(
    .C_FIFO_DEPTH (Depth),
    .C_INIT_POS   (8'd128)
  ) dut (
    .CK_i        (clk),
    .XARST_i     (rst_n),
    .CMD_VAL_i   (val),
    .CMD_RDY_o   (rdy),
    .CMD_POS_i   (cpos),
    .CMD_RATE_i  (crate),
    .CMD_DWELL_i (cdwell),
    .ABORT_i     (abort),
    .FRAME_i     (frame),
    .DAT_o       (dat),
    .BUSY_o      (busy),
    .DONE_o      (done),
    .LEVEL_o     (level)
  );

  typedef struct {
    bit is_done;  // 1: completion (val = frame ticks from command start), 0: DAT change
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  model_pos = 128;
  int  pushed_cnt = 0;
  int  done_cnt = 0;
  int  cmd_ticks = 0;
  int  mon_dat = 128;
  bit  frame_prev;
  bit  mon_tk;
  bit  tick_d1 = 0;
  bit  tick_d2 = 0;
  ev_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input bit is_done, input int v);
    ev_t e;
    e.is_done = is_done;
    e.val     = v;
    exp_q.push_back(e);
  endtask

  // Trajectory of one command from the position the previous command left.
  task automatic model_add(input int tgt, input int rate, input int dwell);
    int p;
    int n;
    int d;
    int mag;
    bit arrived;
    p = model_pos;
    n = 0;
    arrived = 0;
    while (!arrived) begin
      d   = tgt - p;
      mag = (d < 0) ? -d : d;
      n++;
      if (rate == 0 || mag <= rate) begin
        arrived = 1;
        if (dwell == 0) begin
          push_ev(1, n);
          if (tgt != p) push_ev(0, tgt);
        end else begin
          if (tgt != p) push_ev(0, tgt);
          push_ev(1, n + dwell);
        end
      end else begin
        p = (d > 0) ? p + rate : p - rate;
        push_ev(0, p);
      end
    end
    model_pos = tgt;
    pushed_cnt++;
  endtask

  // Frame-start detection as the driver defines it (edge register resets high).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_prev <= 1'b1;
    else        frame_prev <= frame;
  end

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      mon_tk = frame && !frame_prev;
      if (mon_tk && pushed_cnt > done_cnt) cmd_ticks++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_order", int'(mon_e.is_done), 1);
          if (mon_e.is_done) check("done_ticks", cmd_ticks, mon_e.val);
          check("done_near_tick", int'(mon_tk | tick_d1), 1);
        end
        cmd_ticks = 0;
        done_cnt++;
      end
      if (int'(dat) != mon_dat) begin
        if (exp_q.size() == 0) begin
          check("dat_unexpected", int'(dat), mon_dat);
        end else begin
          mon_e = exp_q.pop_front();
          check("step_order", int'(mon_e.is_done), 0);
          check("step_val", int'(dat), mon_e.val);
          check("step_after_tick", int'(tick_d1 | tick_d2), 1);
        end
        mon_dat = int'(dat);
      end
      tick_d2 = tick_d1;
      tick_d1 = mon_tk;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leading gap lets a just-pushed command reach SLEW before the frame starts.
  task automatic frames(input int n);
    repeat (n) begin
      cyc(3);
      frame = 1'b1;
      cyc(4);
      frame = 1'b0;
      cyc(9);
    end
  endtask

  task automatic push_cmd(input int pos, input int rate, input int dwell);
    int w;
    w      = 0;
    val    = 1'b1;
    cpos   = 8'(pos);
    crate  = 4'(rate);
    cdwell = 8'(dwell);
    while (!rdy && w < 50) begin
      cyc(1);
      w++;
    end
    if (!rdy) begin
      n_checks++;
      n_errors++;
      $display("FAIL push_timeout: ready stayed 0, expected 1");
      val = 1'b0;
    end else begin
      cyc(1);
      val = 1'b0;
      model_add(pos, rate, dwell);
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    exp_q.delete();
    pushed_cnt = done_cnt;
    cmd_ticks  = 0;
    model_pos  = mon_dat;
    #1;
    check("abort_rdy_low", int'(rdy), 0);
    cyc(2);
    abort = 1'b0;
    #1;
    check("abort_level", int'(level), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_dat_hold", int'(dat), model_pos);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (pushed_cnt != done_cnt && n < 2000) begin
      frames(1);
      n++;
    end
    check("drain_complete", pushed_cnt - done_cnt, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    check("reset_dat", int'(dat), 128);
    check("reset_rdy", int'(rdy), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_level", int'(level), 0);
    cyc(5);
    check("reset_no_tick_frame_high", int'(dat), 128);
    frame = 1'b0;
    cyc(4);

    // Ramp 128 -> 140 at 5 per frame
    d0 = done_cnt;
    push_cmd(140, 5, 0);
    frames(1);
    check("ramp_f1", int'(dat), 133);
    frames(1);
    check("ramp_f2", int'(dat), 138);
    frames(1);
    check("ramp_f3", int'(dat), 140);
    check("ramp_done", done_cnt - d0, 1);
    check("ramp_busy_low", int'(busy), 0);

    // Jump to 10 with a 3-frame dwell
    push_cmd(128, 0, 0);
    frames(1);
    d0 = done_cnt;
    push_cmd(10, 0, 3);
    frames(1);
    check("jump_dat", int'(dat), 10);
    frames(2);
    check("dwell_no_early_done", done_cnt - d0, 0);
    frames(1);
    check("dwell_done", done_cnt - d0, 1);

    // FIFO fill while a command is parked in SLEW
    push_cmd(10, 1, 1);
    cyc(3);
    push_cmd(20, 0, 0);
    push_cmd(30, 0, 0);
    push_cmd(40, 0, 0);
    push_cmd(50, 0, 0);
    check("fifo_level_full", int'(level), 4);
    check("fifo_rdy_full", int'(rdy), 0);
    frames(2);
    check("fifo_level_after_pop", int'(level), 3);
    check("fifo_rdy_after_pop", int'(rdy), 1);
    push_cmd(60, 0, 0);
    drain();
    check("fifo_final_dat", int'(dat), 60);

    // Abort mid-slew at 60 with two queued commands
    push_cmd(65, 0, 0);
    frames(1);
    push_cmd(10, 5, 0);
    frames(1);
    check("abort_pre_dat", int'(dat), 60);
    push_cmd(100, 0, 0);
    push_cmd(200, 0, 0);
    check("abort_pre_level", int'(level), 2);
    d0 = done_cnt;
    do_abort();
    frames(2);
    check("abort_post_dat", int'(dat), 60);
    check("abort_no_done", done_cnt - d0, 0);

    // Target already reached; then full-scale 255 -> 0 descent
    d0 = done_cnt;
    push_cmd(60, 7, 0);
    frames(1);
    check("same_pos_done", done_cnt - d0, 1);
    check("same_pos_dat", int'(dat), 60);
    push_cmd(255, 0, 0);
    frames(1);
    d0 = done_cnt;
    push_cmd(0, 15, 0);
    frames(17);
    check("descent_dat", int'(dat), 0);
    check("descent_done", done_cnt - d0, 1);

    // Frame start falls in the LOAD cycle
    d0 = done_cnt;
    push_cmd(77, 0, 0);
    cyc(1);
    frame = 1'b1;
    cyc(4);
    frame = 1'b0;
    cyc(12);
    check("load_tick_dat", int'(dat), 77);
    check("load_tick_done", done_cnt - d0, 1);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        if (rdy) push_cmd(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)));
        else frames(1);
      end else if (r < 9) begin
        frames(1);
      end else begin
        do_abort();
      end
    end
    drain();
    check("final_exp_empty", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
